// File: rtl/lcd_timing_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_timing_pkg                                                       |
// | Shared phase encoding, default 480x272 timing and phase helpers.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package lcd_timing_pkg;

  typedef enum logic [1:0] {
    PH_SYNC   = 2'd0,
    PH_BACK   = 2'd1,
    PH_ACTIVE = 2'd2,
    PH_FRONT  = 2'd3
  } phase_t;

  localparam int c_len_w = 16;
  localparam logic [c_len_w-1:0] c_one = c_len_w'(1);

  localparam int c_h_active_dflt = 480;
  localparam int c_h_fp_dflt     = 2;
  localparam int c_h_sync_dflt   = 41;
  localparam int c_h_bp_dflt     = 2;
  localparam int c_v_active_dflt = 272;
  localparam int c_v_fp_dflt     = 2;
  localparam int c_v_sync_dflt   = 10;
  localparam int c_v_bp_dflt     = 2;

  function automatic logic [c_len_w-1:0] phase_len(
    input phase_t             ph,
    input logic [c_len_w-1:0] len_sync,
    input logic [c_len_w-1:0] len_back,
    input logic [c_len_w-1:0] len_active,
    input logic [c_len_w-1:0] len_front
  );
    case (ph)
      PH_SYNC:   return len_sync;
      PH_BACK:   return len_back;
      PH_ACTIVE: return len_active;
      PH_FRONT:  return len_front;
      default:   return len_sync;
    endcase
  endfunction

  function automatic phase_t phase_next(input phase_t ph);
    case (ph)
      PH_SYNC:   return PH_BACK;
      PH_BACK:   return PH_ACTIVE;
      PH_ACTIVE: return PH_FRONT;
      PH_FRONT:  return PH_SYNC;
      default:   return PH_SYNC;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_phase_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_phase_counter                                                    |
// | One raster axis: SYNC->BACK->ACTIVE->FRONT phase FSM + down-counter. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lcd_phase_counter
  import lcd_timing_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_step,
  input  logic [c_len_w-1:0] i_len_sync,
  input  logic [c_len_w-1:0] i_len_back,
  input  logic [c_len_w-1:0] i_len_active,
  input  logic [c_len_w-1:0] i_len_front,
  output logic [1:0]         o_phase,
  output logic [c_len_w-1:0] o_cnt,
  output logic               o_wrap
);

  phase_t             r_phase;
  logic [c_len_w-1:0] r_cnt;
  phase_t             w_next_phase;

  assign w_next_phase = phase_next(r_phase);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= PH_SYNC;
      r_cnt   <= i_len_sync - c_one;
    end else if (i_step) begin
      if (r_cnt == '0) begin
        r_phase <= w_next_phase;
        r_cnt   <= phase_len(w_next_phase, i_len_sync, i_len_back,
                             i_len_active, i_len_front) - c_one;
      end else begin
        r_cnt <= r_cnt - c_one;
      end
    end
  end

  assign o_phase = r_phase;
  assign o_cnt   = r_cnt;
  // Last step of FRONT: the axis is about to wrap back into SYNC.
  assign o_wrap  = i_step && (r_phase == PH_FRONT) && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/lcd_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_timing_gen                                                       |
// | Parallel-RGB LCD raster timing: hsync/vsync/lcden, x/y, sof.         |
// | Option macro LCD_TIMING_FRAME_CNT_EN adds the o_frame_cnt output.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int H_ACTIVE = c_h_active_dflt,
  parameter int H_FP     = c_h_fp_dflt,
  parameter int H_SYNC   = c_h_sync_dflt,
  parameter int H_BP     = c_h_bp_dflt,
  parameter int V_ACTIVE = c_v_active_dflt,
  parameter int V_FP     = c_v_fp_dflt,
  parameter int V_SYNC   = c_v_sync_dflt,
  parameter int V_BP     = c_v_bp_dflt,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  output logic                        o_hsync,
  output logic                        o_vsync,
  output logic                        o_lcden,
  output logic [$clog2(H_ACTIVE)-1:0] o_x,
  output logic [$clog2(V_ACTIVE)-1:0] o_y,
  output logic                        o_sof
`ifdef LCD_TIMING_FRAME_CNT_EN
  ,
  output logic [7:0]                  o_frame_cnt
`endif
);

  localparam int c_x_w = $clog2(H_ACTIVE);
  localparam int c_y_w = $clog2(V_ACTIVE);

  localparam logic [c_len_w-1:0] c_h_sync   = c_len_w'(H_SYNC);
  localparam logic [c_len_w-1:0] c_h_back   = c_len_w'(H_BP);
  localparam logic [c_len_w-1:0] c_h_active = c_len_w'(H_ACTIVE);
  localparam logic [c_len_w-1:0] c_h_front  = c_len_w'(H_FP);
  localparam logic [c_len_w-1:0] c_v_sync   = c_len_w'(V_SYNC);
  localparam logic [c_len_w-1:0] c_v_back   = c_len_w'(V_BP);
  localparam logic [c_len_w-1:0] c_v_active = c_len_w'(V_ACTIVE);
  localparam logic [c_len_w-1:0] c_v_front  = c_len_w'(V_FP);
  localparam logic [c_len_w-1:0] c_h_last   = c_len_w'(H_ACTIVE - 1);
  localparam logic [c_len_w-1:0] c_v_last   = c_len_w'(V_ACTIVE - 1);

  generate
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_len_check
      $error("lcd_timing_gen: every phase length must be at least 1");
    end
  endgenerate

  logic [1:0]         w_h_phase;
  logic [1:0]         w_v_phase;
  logic [c_len_w-1:0] w_h_cnt;
  logic [c_len_w-1:0] w_v_cnt;
  logic               w_h_wrap;
  logic               w_v_wrap;
  logic               w_h_active;
  logic               w_v_active;

  logic               r_at_start;
  logic               r_hsync;
  logic               r_vsync;
  logic               r_lcden;
  logic               r_sof;
  logic [c_x_w-1:0]   r_x;
  logic [c_y_w-1:0]   r_y;

  lcd_phase_counter u_h_axis (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_step       (1'b1),
    .i_len_sync   (c_h_sync),
    .i_len_back   (c_h_back),
    .i_len_active (c_h_active),
    .i_len_front  (c_h_front),
    .o_phase      (w_h_phase),
    .o_cnt        (w_h_cnt),
    .o_wrap       (w_h_wrap)
  );

  lcd_phase_counter u_v_axis (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_step       (w_h_wrap),
    .i_len_sync   (c_v_sync),
    .i_len_back   (c_v_back),
    .i_len_active (c_v_active),
    .i_len_front  (c_v_front),
    .o_phase      (w_v_phase),
    .o_cnt        (w_v_cnt),
    .o_wrap       (w_v_wrap)
  );

  assign w_h_active = (w_h_phase == PH_ACTIVE);
  assign w_v_active = (w_v_phase == PH_ACTIVE);

  // Ports lag the axis state by one register stage; r_at_start marks
  // that the state currently sits on frame clock 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_at_start <= 1'b1;
      r_sof      <= 1'b0;
      r_hsync    <= SYNC_POL;
      r_vsync    <= SYNC_POL;
      r_lcden    <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
    end else begin
      r_at_start <= w_v_wrap;
      r_sof      <= r_at_start;
      r_hsync    <= (w_h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      r_vsync    <= (w_v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      r_lcden    <= w_h_active && w_v_active;
      r_x        <= w_h_active ? c_x_w'(c_h_last - w_h_cnt) : '0;
      r_y        <= w_v_active ? c_y_w'(c_v_last - w_v_cnt) : '0;
    end
  end

  assign o_hsync = r_hsync;
  assign o_vsync = r_vsync;
  assign o_lcden = r_lcden;
  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_sof   = r_sof;

`ifdef LCD_TIMING_FRAME_CNT_EN
  logic       r_first_sof;
  logic [7:0] r_frame_cnt;

  // Counts frames after the first; steps in the same cycle o_sof rises.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_first_sof <= 1'b1;
      r_frame_cnt <= '0;
    end else if (r_at_start) begin
      r_first_sof <= 1'b0;
      if (!r_first_sof) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  assign o_frame_cnt = r_frame_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lcd_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lcd_timing_gen                                                    |
// | Checks three timing configurations against an arithmetic raster     |
// | model, with randomly placed asynchronous resets.                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_lcd_timing_gen;

  typedef struct {
    int hs; int hb; int ha; int hf;
    int vs; int vb; int va; int vf;
    bit pol;
  } cfg_t;

  typedef struct {
    bit hsync; bit vsync; bit lcden; bit sof;
    int x; int y; int fcnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cfg_t cfg [3];
  int   t = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic        hs [3];
  logic        vs [3];
  logic        de [3];
  logic        sf [3];
  logic [31:0] ox [3];
  logic [31:0] oy [3];
  logic [31:0] fc [3];

  logic [8:0] x0; logic [8:0] y0;
  logic [1:0] x1; logic [0:0] y1;
  logic [3:0] x2; logic [2:0] y2;
  assign ox[0] = 32'(x0); assign oy[0] = 32'(y0);
  assign ox[1] = 32'(x1); assign oy[1] = 32'(y1);
  assign ox[2] = 32'(x2); assign oy[2] = 32'(y2);

`ifdef LCD_TIMING_FRAME_CNT_EN
  logic [7:0] f0; logic [7:0] f1; logic [7:0] f2;
  assign fc[0] = 32'(f0); assign fc[1] = 32'(f1); assign fc[2] = 32'(f2);
`else
  assign fc[0] = '0; assign fc[1] = '0; assign fc[2] = '0;
`endif

  lcd_timing_gen u_dut_def (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_hsync(hs[0]), .o_vsync(vs[0]), .o_lcden(de[0]),
    .o_x(x0), .o_y(y0), .o_sof(sf[0])
`ifdef LCD_TIMING_FRAME_CNT_EN
    , .o_frame_cnt(f0)
`endif
  );

  lcd_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
  ) u_dut_small (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_hsync(hs[1]), .o_vsync(vs[1]), .o_lcden(de[1]),
    .o_x(x1), .o_y(y1), .o_sof(sf[1])
`ifdef LCD_TIMING_FRAME_CNT_EN
    , .o_frame_cnt(f1)
`endif
  );

  lcd_timing_gen #(
    .H_ACTIVE(16), .H_FP(3), .H_SYNC(5), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)
  ) u_dut_mid (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_hsync(hs[2]), .o_vsync(vs[2]), .o_lcden(de[2]),
    .o_x(x2), .o_y(y2), .o_sof(sf[2])
`ifdef LCD_TIMING_FRAME_CNT_EN
    , .o_frame_cnt(f2)
`endif
  );

  // Raster position from elapsed frame clocks, by plain division.
  function automatic exp_t model(input cfg_t c, input int tt);
    exp_t e;
    int lp, fp, p, line, col, ha0, va0;
    bit hact, vact;
    lp   = c.hs + c.hb + c.ha + c.hf;
    fp   = lp * (c.vs + c.vb + c.va + c.vf);
    p    = tt % fp;
    line = p / lp;
    col  = p % lp;
    ha0  = c.hs + c.hb;
    va0  = c.vs + c.vb;
    hact = (col >= ha0) && (col < ha0 + c.ha);
    vact = (line >= va0) && (line < va0 + c.va);
    e.hsync = (col < c.hs) ? c.pol : !c.pol;
    e.vsync = (line < c.vs) ? c.pol : !c.pol;
    e.lcden = hact && vact;
    e.x     = hact ? col - ha0 : 0;
    e.y     = vact ? line - va0 : 0;
    e.sof   = (p == 0);
    e.fcnt  = (tt / fp) % 256;
    return e;
  endfunction

  function automatic exp_t reset_exp(input cfg_t c);
    exp_t e;
    e.hsync = c.pol; e.vsync = c.pol; e.lcden = 1'b0; e.sof = 1'b0;
    e.x = 0; e.y = 0; e.fcnt = 0;
    return e;
  endfunction

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0d, time %0t)", tag, got, exp, t, $time);
    end
  endtask

  task automatic check_all(input bit in_reset);
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e = in_reset ? reset_exp(cfg[k]) : model(cfg[k], t);
      check_value($sformatf("d%0d_hsync", k), 32'(hs[k]), 32'(e.hsync));
      check_value($sformatf("d%0d_vsync", k), 32'(vs[k]), 32'(e.vsync));
      check_value($sformatf("d%0d_lcden", k), 32'(de[k]), 32'(e.lcden));
      check_value($sformatf("d%0d_sof", k),   32'(sf[k]), 32'(e.sof));
      check_value($sformatf("d%0d_x", k),     ox[k],      32'(e.x));
      check_value($sformatf("d%0d_y", k),     oy[k],      32'(e.y));
`ifdef LCD_TIMING_FRAME_CNT_EN
      check_value($sformatf("d%0d_frame_cnt", k), fc[k], 32'(e.fcnt));
`endif
    end
  endtask

  bit agg_en = 1'b0;
  int cnt_hs0 = 0, cnt_de0_l0 = 0, cnt_vs0 = 0, first_de0 = -1, cnt_sof0 = 0;
  int cnt_hs1 = 0, cnt_de1 = 0, cnt_sof1 = 0, cnt_de2 = 0;

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check_all(1'b0);
      if (agg_en) begin
        if (t < 525 && hs[0] === 1'b1) cnt_hs0++;
        if (t < 525 && de[0] === 1'b1) cnt_de0_l0++;
        if (vs[0] === 1'b1) cnt_vs0++;
        if (de[0] === 1'b1 && first_de0 < 0) first_de0 = t;
        if (sf[0] === 1'b1) cnt_sof0++;
        if (t < 7 && hs[1] === 1'b0) cnt_hs1++;
        if (t < 35 && de[1] === 1'b1) cnt_de1++;
        if (sf[1] === 1'b1) cnt_sof1++;
        if (t < 312 && de[2] === 1'b1) cnt_de2++;
      end
      t++;
    end
  endtask

  // Reset lands mid-cycle; outputs must already be at reset values 1 ns later.
  task automatic async_reset(input int hold);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_all(1'b1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_all(1'b1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got incomplete run expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg[0] = '{hs:41, hb:2, ha:480, hf:2, vs:10, vb:2, va:272, vf:2, pol:1'b1};
    cfg[1] = '{hs:1,  hb:1, ha:4,   hf:1, vs:1,  vb:1, va:2,   vf:1, pol:1'b0};
    cfg[2] = '{hs:5,  hb:2, ha:16,  hf:3, vs:2,  vb:3, va:6,   vf:1, pol:1'b1};

    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_all(1'b1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;

    agg_en = 1'b1;
    run(7000);
    agg_en = 1'b0;
    check_value("d0_hsync_clks_line0", 32'(cnt_hs0),    32'd41);
    check_value("d0_lcden_clks_line0", 32'(cnt_de0_l0), 32'd0);
    check_value("d0_vsync_clks",       32'(cnt_vs0),    32'd5250);
    check_value("d0_first_lcden_t",    32'(first_de0),  32'(12 * 525 + 43));
    check_value("d0_sof_count",        32'(cnt_sof0),   32'd1);
    check_value("d1_hsync_low_line0",  32'(cnt_hs1),    32'd1);
    check_value("d1_lcden_frame0",     32'(cnt_de1),    32'd8);
    check_value("d1_sof_count",        32'(cnt_sof1),   32'd200);
    check_value("d2_lcden_frame0",     32'(cnt_de2),    32'd96);

    // Default config is mid-active-line here (line 13, column 175).
    async_reset(int'($urandom_range(0, 3)));
    for (int r = 0; r < 3; r++) begin
      run(int'($urandom_range(100, 3000)));
      async_reset(int'($urandom_range(0, 3)));
    end

    // Long enough for the small config's frame counter to wrap 255 -> 0.
    run(9100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
